sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO; next generation of the team's 8-bit write/read FIFO.
Generalises data width and depth, and adds:
- occupancy count
- programmable almost-full / almost-empty thresholds
- sticky overflow / underflow error flags
- selectable standard (registered read) or first-word-fall-through (FWFT) output mode

Used as the elastic buffer between producer and consumer stages sharing one clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AF_THRESH, 12, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard mode (data after read), 1 = first-word-fall-through

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
wr_en  input  1  write request
data_in  input  DATA_W  write data
rd_en  input  1  read request (pop)
clr_err  input  1  synchronous clear of overflow/underflow
data_out  output  DATA_W  read data
fifo_full  output  1  count == DEPTH
fifo_empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=0, asynchronous):
  - pointers = 0, count = 0, data_out = 0, overflow = underflow = 0
  - fifo_empty = 1, almost_empty = 1, fifo_full = 0, almost_full = 0
  - storage contents are not reset
- Reset mid-operation: all stored data is discarded. After release, the FIFO is empty and the first write lands at address 0.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately, so full and empty are never ambiguous.
- Write accepted (wr_ok) = wr_en & (!fifo_full | rd_ok). If full, a write is accepted only when a read is accepted in the same cycle.
- Read accepted (rd_ok) = rd_en & !fifo_empty. A read is never accepted on an empty FIFO, even with a simultaneous write.
- count update per cycle:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged on both or neither
- All flags decode combinationally from registered count, so there is no extra flag latency. After a write to an empty FIFO, fifo_empty deasserts on the next edge.
- Standard mode (FWFT=0):
  - on rd_ok, data_out <= mem[rd_ptr] at the edge (1-cycle read latency)
  - otherwise data_out holds its last value
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] whenever !fifo_empty, and 0 when empty
  - rd_ok pops and advances to the next word
  - a word written into an empty FIFO appears on data_out the cycle after the write edge
- Error flags:
  - overflow <= 1 when wr_en & !wr_ok
  - underflow <= 1 when rd_en & !rd_ok
  - both hold until clr_err=1 or reset
  - if clr_err and a new error occur in the same cycle, the new error wins (flag stays 1)
- Rejected operations leave pointers, count and storage untouched.
- Parameter checks: the elaboration-time check rejects a non-power-of-two DEPTH, and rejects AF_THRESH or AE_THRESH outside their ranges.

Decomposition:
- Shared package fifo_pkg holds:
  - the PTR_W / CNT_W width function ($clog2-based)
  - mode constants FIFO_STD=0 and FIFO_FWFT=1
  - a threshold-range check function reused by future FIFO variants
- One sub-module, fifo_mem_dp: DEPTH x DATA_W register-array memory with one synchronous write port and an asynchronous read port.
- Pointer, count, flag and output logic live in sync_fifo_param.

Test Plan:
1. Reset/fill: DEPTH=16, FWFT=0.
   - Stimulus: assert rst=0 mid-stream, release, then write 0x01,0x02,0x04,0x08.
   - Response: count=4, fifo_empty=0, almost_empty=0 after the 3rd write.
   - Response: reads return 0x01,0x02,0x04,0x08, each one cycle after rd_en.
2. Full/overflow: 16 writes of 0x10..0x1F, then a 17th write of 0xFF.
   - Response: fifo_full=1 and almost_full=1 (from count=12).
   - Response: overflow=1, count stays 16, 0xFF is never read back.
   - Response: clr_err clears overflow.
3. Simultaneous read+write:
   - When full: wr_en=rd_en=1 -> count stays 16, oldest word out, new word stored; a later drain shows the correct order.
   - When empty: wr_en=rd_en=1 -> underflow=1, count=1.
4. Wrap-around: 40 write/read pairs with an incrementing pattern at occupancy ~5.
   - Response: every output matches the input order; pointers wrap twice without data corruption.
5. FWFT=1: write 0xA5 into an empty FIFO.
   - Response: data_out=0xA5 the next cycle with no rd_en.
   - Response: rd_en pops; fifo_empty=1; data_out=0.
6. Underflow sticky: rd_en on an empty FIFO for 3 cycles.
   - Response: underflow=1 and it stays set across later valid traffic until clr_err.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer/count width helpers, output mode constants, parameter range checks.
// Pure compile-time content; no logic, no latency, no flow control.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a full FIFO (count == depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_W register-array storage: synchronous write, asynchronous (same-cycle) read.
// No backpressure; the caller only asserts wr_en for accepted writes.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ptr_w(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ptr_w(DEPTH)-1:0]  rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with count, almost flags, sticky errors; 1-cycle read latency (std) or fall-through (FWFT).
// Full refuses writes unless a read pops in the same cycle; empty refuses reads; refusals set sticky error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FIFO_STD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    rd_en,
  input  logic                    clr_err,
  output logic [DATA_W-1:0]       data_out,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("sync_fifo_param: AF_THRESH/AE_THRESH out of range");
  end
  if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rd_data;
  logic              wr_ok;
  logic              rd_ok;

  assign rd_ok = rd_en & ~fifo_empty;
  // A full FIFO can still take a write when the same cycle frees a slot.
  assign wr_ok = wr_en & (~fifo_full | rd_ok);

  assign count        = cnt_q;
  assign fifo_empty   = (cnt_q == '0);
  assign fifo_full    = (cnt_q == CNT_W'(DEPTH));
  assign almost_full  = (cnt_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (cnt_q <= CNT_W'(AE_THRESH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // A fresh error in the clearing cycle wins over clr_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & ~wr_ok)  overflow <= 1'b1;
      else if (clr_err)    overflow <= 1'b0;
      if (rd_en & ~rd_ok)  underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign data_out = fifo_empty ? '0 : rd_data;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= rd_data;
      end
    end

    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: standard-mode and FWFT-mode instances, queue scoreboard per instance.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_wr, f_rd, f_clr;
  logic [7:0] f_din;
  logic [7:0] f_dout;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] f_count;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow));

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)) dut_fw (
    .clk(clk), .rst(rst), .wr_en(f_wr), .data_in(f_din), .rd_en(f_rd), .clr_err(f_clr),
    .data_out(f_dout), .fifo_full(f_full), .fifo_empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf));

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  int         mcount = 0;
  bit         movf = 0, mudf = 0;
  bit         rd_hit;
  logic [7:0] rd_exp;
  logic [7:0] fq[$];

  // Drive one cycle on the standard instance and advance the reference model.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit rok, wok;
    wr_en = w; data_in = d; rd_en = r; clr_err = c;
    rok = r && (mcount > 0);
    wok = w && ((mcount < 16) || rok);
    rd_hit = rok;
    if (rok) rd_exp = exp_q.pop_front();
    if (wok) exp_q.push_back(d);
    mcount = mcount + int'(wok) - int'(rok);
    movf = (w && !wok) ? 1'b1 : (c ? 1'b0 : movf);
    mudf = (r && !rok) ? 1'b1 : (c ? 1'b0 : mudf);
    @(posedge clk); #1;
  endtask

  task automatic fstep(input logic w, input logic [7:0] d, input logic r);
    f_wr = w; f_din = d; f_rd = r;
    if (r && fq.size() > 0) void'(fq.pop_front());
    if (w && fq.size() < 16) fq.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wr_en = 0; rd_en = 0; clr_err = 0; data_in = 0;
    f_wr = 0; f_rd = 0; f_clr = 0; f_din = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if ({fifo_empty, almost_empty, fifo_full, almost_full} !== 4'b1100) begin
      failures++; $display("FAIL rst_flags got=%b exp=1100", {fifo_empty, almost_empty, fifo_full, almost_full}); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL rst_err got=%b exp=00", {overflow, underflow}); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_dout got=%0h exp=0", data_out); end
    checks++; if (f_dout !== 8'h00 || f_empty !== 1'b1) begin
      failures++; $display("FAIL rst_fwft got=%0h/%b exp=0/1", f_dout, f_empty); end
    rst = 1'b1;
    step(1, 8'hEE, 0, 0);
    step(1, 8'hDD, 0, 0);
    step(0, 8'h00, 0, 0);
    // Asynchronous reset mid-stream, checked before the next clock edge.
    #2 rst = 1'b0;
    #1;
    checks++; if (count !== 5'd0 || fifo_empty !== 1'b1) begin
      failures++; $display("FAIL async_rst got=%0d/%b exp=0/1", count, fifo_empty); end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete(); mcount = 0; movf = 0; mudf = 0;
  endtask

  task automatic test_fill();
    logic [7:0] pat[4];
    pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h04; pat[3] = 8'h08;
    for (int i = 0; i < 4; i++) begin
      step(1, pat[i], 0, 0);
      if (i == 2) begin
        checks++; if (count !== 5'd3 || fifo_empty !== 1'b0 || almost_empty !== 1'b0) begin
          failures++; $display("FAIL fill3 got=%0d/%b/%b exp=3/0/0", count, fifo_empty, almost_empty); end
      end
    end
    checks++; if (count !== 5'd4) begin failures++; $display("FAIL fill4_count got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 1, 0);
      checks++; if (!rd_hit || data_out !== rd_exp || data_out !== pat[i]) begin
        failures++; $display("FAIL fill_read%0d got=%0h exp=%0h", i, data_out, pat[i]); end
    end
    step(0, 8'h00, 0, 0);
    checks++; if (data_out !== 8'h08 || fifo_empty !== 1'b1) begin
      failures++; $display("FAIL dout_hold got=%0h/%b exp=8/1", data_out, fifo_empty); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 16; i++) begin
      step(1, 8'h10 + 8'(i), 0, 0);
      checks++; if (almost_full !== (i + 1 >= 12)) begin
        failures++; $display("FAIL af_at%0d got=%b exp=%b", i + 1, almost_full, (i + 1 >= 12)); end
    end
    checks++; if (fifo_full !== 1'b1 || count !== 5'd16) begin
      failures++; $display("FAIL full got=%b/%0d exp=1/16", fifo_full, count); end
    step(1, 8'hFF, 0, 0);
    checks++; if (overflow !== 1'b1 || count !== 5'd16) begin
      failures++; $display("FAIL overflow got=%b/%0d exp=1/16", overflow, count); end
    step(0, 8'h00, 0, 1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
  endtask

  task automatic test_simul_rw();
    step(1, 8'hA0, 1, 0);
    checks++; if (count !== 5'd16 || data_out !== 8'h10 || overflow !== 1'b0) begin
      failures++; $display("FAIL rw_full got=%0d/%0h/%b exp=16/10/0", count, data_out, overflow); end
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 1, 0);
      checks++; if (data_out !== rd_exp || data_out === 8'hFF) begin
        failures++; $display("FAIL drain%0d got=%0h exp=%0h", i, data_out, rd_exp); end
    end
    checks++; if (rd_exp !== 8'hA0 || fifo_empty !== 1'b1) begin
      failures++; $display("FAIL drain_last got=%0h/%b exp=a0/1", rd_exp, fifo_empty); end
    step(1, 8'h55, 1, 0);
    checks++; if (underflow !== 1'b1 || count !== 5'd1) begin
      failures++; $display("FAIL rw_empty got=%b/%0d exp=1/1", underflow, count); end
    step(0, 8'h00, 1, 1);
    checks++; if (data_out !== 8'h55 || underflow !== 1'b0) begin
      failures++; $display("FAIL rw_empty_rd got=%0h/%b exp=55/0", data_out, underflow); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 8'h65 + 8'(i), 1, 0);
      checks++; if (data_out !== rd_exp || count !== 5'd5) begin
        failures++; $display("FAIL wrap%0d got=%0h/%0d exp=%0h/5", i, data_out, count, rd_exp); end
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 1, 0);
      checks++; if (data_out !== 8'h60 + 8'(40 + i)) begin
        failures++; $display("FAIL wrap_drain%0d got=%0h exp=%0h", i, data_out, 8'h60 + 8'(40 + i)); end
    end
  endtask

  task automatic test_underflow_sticky();
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 1, 0);
      checks++; if (underflow !== 1'b1 || count !== 5'd0) begin
        failures++; $display("FAIL udf%0d got=%b/%0d exp=1/0", i, underflow, count); end
    end
    step(1, 8'h33, 0, 0);
    step(1, 8'h44, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    checks++; if (underflow !== 1'b1 || data_out !== 8'h44) begin
      failures++; $display("FAIL udf_sticky got=%b/%0h exp=1/44", underflow, data_out); end
    step(0, 8'h00, 0, 1);
    checks++; if (underflow !== mudf || underflow !== 1'b0) begin
      failures++; $display("FAIL udf_clr got=%b exp=0", underflow); end
  endtask

  task automatic test_fwft();
    fstep(1, 8'hA5, 0);
    checks++; if (f_dout !== 8'hA5 || f_empty !== 1'b0) begin
      failures++; $display("FAIL fwft_fall got=%0h/%b exp=a5/0", f_dout, f_empty); end
    fstep(0, 8'h00, 0);
    checks++; if (f_dout !== 8'hA5) begin failures++; $display("FAIL fwft_hold got=%0h exp=a5", f_dout); end
    fstep(0, 8'h00, 1);
    checks++; if (f_empty !== 1'b1 || f_dout !== 8'h00) begin
      failures++; $display("FAIL fwft_pop got=%b/%0h exp=1/0", f_empty, f_dout); end
    fstep(1, 8'h11, 0);
    fstep(1, 8'h22, 0);
    for (int i = 0; i < 2; i++) begin
      checks++; if (f_dout !== fq[0]) begin
        failures++; $display("FAIL fwft_order%0d got=%0h exp=%0h", i, f_dout, fq[0]); end
      fstep(0, 8'h00, 1);
    end
    checks++; if (f_empty !== 1'b1 || f_dout !== 8'h00 || f_udf !== 1'b0) begin
      failures++; $display("FAIL fwft_end got=%b/%0h/%b exp=1/0/0", f_empty, f_dout, f_udf); end
    fstep(0, 8'h00, 0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_overflow();
    test_simul_rw();
    test_wrap();
    test_underflow_sticky();
    test_fwft();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
